// File: rtl/ddr_rd_burst_axi_bridge.sv
// ---------------------------------------------------------------------------
// ddr_rd_burst_axi_bridge
//
// Converts a simple burst read request (addr + length in beats) into a single
// AXI4 INCR read transaction and streams the returned beats back as one-cycle
// data strobes, followed by a one-cycle finish pulse.
//
// Ports:
//   s_clk, s_rst         clock, asynchronous active-high reset
//   rd_burst_req/addr/len   request side (len in beats, 1..256 legal)
//   rd_burst_data/valid     returned beat data and its one-cycle strobe
//   rd_burst_finish         one-cycle end-of-burst pulse
//   m_ar*                   AXI4 read address channel (ID fixed to 0)
//   m_r*                    AXI4 read data channel
//   err_clr                 clears the sticky error flags
//   o_err                   sticky error flags {len, rlast, resp}
// ---------------------------------------------------------------------------
module ddr_rd_burst_axi_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  rd_burst_req,
    input  logic [ADDR_SIZE-1:0]  rd_burst_addr,
    input  logic [LEN_WIDTH-1:0]  rd_burst_len,
    output logic [DATA_WIDTH-1:0] rd_burst_data,
    output logic                  rd_burst_valid,
    output logic                  rd_burst_finish,
    output logic [ADDR_SIZE-1:0]  m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic                  err_clr,
    output logic [2:0]            o_err
);

    localparam logic [2:0]           AR_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(256);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    finish_q, finish_d;
    logic [2:0]              err_q, err_d;
    // Low for the first edge after reset release so that a request is
    // accepted no earlier than the second edge.
    logic                    armed_q;

    logic                    len_bad;
    logic                    last_beat;

    assign len_bad   = (rd_burst_len == '0) || (rd_burst_len > MAX_LEN);
    assign last_beat = (cnt_q == len_q - ONE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        arlen_d  = arlen_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        finish_d = 1'b0;
        // Clear first, then OR in new events so that a coincident set wins.
        err_d    = err_clr ? 3'b000 : err_q;

        unique case (state_q)
            ST_IDLE: begin
                // finish_q is high exactly in the IDLE cycle right after DONE;
                // blocking acceptance there lets the requester drop its request
                // one cycle after finish without a spurious re-issue.
                if (rd_burst_req && armed_q && !finish_q) begin
                    if (len_bad) begin
                        err_d[2] = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        addr_d  = rd_burst_addr;
                        len_d   = rd_burst_len;
                        arlen_d = 8'(rd_burst_len - ONE);
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rvalid) begin
                    data_d  = m_rdata;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + ONE;
                    if (m_rresp != 2'b00) begin
                        err_d[0] = 1'b1;
                    end
                    // Whichever of rlast / expected count comes first ends
                    // the burst; disagreement between them is flagged.
                    if (last_beat || m_rlast) begin
                        if (last_beat != m_rlast) begin
                            err_d[1] = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                finish_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 3'b000;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            arlen_q  <= arlen_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            armed_q  <= 1'b1;
        end
    end

    // Handshake strobes decode directly from the state register so they drop
    // the moment reset is applied.
    assign m_arvalid       = (state_q == ST_ADDR);
    assign m_rready        = (state_q == ST_DATA);
    assign m_araddr        = addr_q;
    assign m_arlen         = arlen_q;
    assign m_arsize        = AR_SIZE;
    assign m_arburst       = 2'b01;
    assign rd_burst_data   = data_q;
    assign rd_burst_valid  = valid_q;
    assign rd_burst_finish = finish_q;
    assign o_err           = err_q;

endmodule
